pcg_bounded_draw: RTL

- Downstream consumer of the PCG32 random-word stream.
- Converts raw 32-bit random words into an unbiased integer uniformly distributed in [0, bound). Uses Lemire multiply-and-reject: a 64-bit product, with rejection below threshold t = (2^W - bound) mod bound.
- Sits between the PCG32 generator and any client needing dice, shuffle indices or bounded jitter. It also backpressures the generator.

---
 rtl/pcg_bounded_draw_pkg.sv | 18 +
 rtl/pcg_bounded_draw_if.sv | 30 +++
 rtl/pcg_bounded_draw_mod_serial.sv | 82 ++++++++
 rtl/pcg_bounded_draw.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pcg_bounded_draw_pkg.sv
// Shared types for the bounded-draw datapath: word/product widths and FSM states.
package pcg_pkg;

  localparam int PCG_W = 32;

  typedef logic [PCG_W-1:0]   pcg_word_t;
  typedef logic [2*PCG_W-1:0] pcg_prod_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_THRESH = 3'd1,
    ST_DRAW   = 3'd2,
    ST_MUL    = 3'd3,
    ST_CHECK  = 3'd4,
    ST_OUT    = 3'd5
  } draw_state_e;

endpackage

// File: rtl/pcg_bounded_draw_if.sv
// Request, random-word and result handshakes of the bounded draw unit.
interface pcg_bounded_draw_if
  import pcg_pkg::*;
#(
  parameter int W     = PCG_W,
  parameter int REJ_W = 8
) ();

  logic             req_valid;
  logic             req_ready;
  logic [W-1:0]     req_bound;
  logic             rnd_valid;
  logic             rnd_ready;
  logic [W-1:0]     rnd_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [REJ_W-1:0] rej_count;

  modport slave (
    input  req_valid, req_bound, rnd_valid, rnd_data, out_ready,
    output req_ready, rnd_ready, out_valid, out_data, rej_count
  );

  modport master (
    output req_valid, req_bound, rnd_valid, rnd_data, out_ready,
    input  req_ready, rnd_ready, out_valid, out_data, rej_count
  );

endinterface

// File: rtl/pcg_bounded_draw_mod_serial.sv
// Serial restoring divider returning only the remainder, one quotient bit per cycle.
// The first bit is resolved on the start cycle, so done rises W-1 cycles later.
module pcg_mod_serial
  import pcg_pkg::*;
#(
  parameter int W = PCG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_rem
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_dvd;
  logic [W-1:0]     r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [W-1:0] w_rem_in;
  logic [W-1:0] w_dvs;
  logic         w_bit;
  logic [W:0]   w_trial;
  logic [W-1:0] w_rem_next;

  always_comb begin
    w_rem_in   = r_rem;
    w_bit      = r_dvd[W-1];
    w_dvs      = r_dvs;
    if (i_start) begin
      w_rem_in = '0;
      w_bit    = i_dividend[W-1];
      w_dvs    = i_divisor;
    end
    w_trial    = {w_rem_in, w_bit};
    w_rem_next = w_trial[W-1:0];
    // Remainder stays below the divisor, so the subtracted value always fits W bits.
    if (w_trial >= {1'b0, w_dvs}) begin
      w_rem_next = W'(w_trial - {1'b0, w_dvs});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_rem_next;
        r_dvd  <= {i_dividend[W-2:0], 1'b0};
        r_dvs  <= i_divisor;
        r_cnt  <= CNT_W'(W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_next;
        r_dvd <= {r_dvd[W-2:0], 1'b0};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_rem  = r_rem;

endmodule

// File: rtl/pcg_bounded_draw.sv
// Unbiased bounded integer from a random word stream (Lemire multiply-and-reject),
// with a one-entry threshold cache keyed on the last bound.
module pcg_bounded_draw
  import pcg_pkg::*;
#(
  parameter int W     = PCG_W,
  parameter int REJ_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  pcg_bounded_draw_if.slave bus
);

  draw_state_e r_state;
  draw_state_e w_state_next;

  logic             r_req_ready;
  logic             r_rnd_ready;
  logic             r_out_valid;
  logic [W-1:0]     r_s;
  logic             r_pass;
  logic [W-1:0]     r_x;
  logic [2*W-1:0]   r_m;
  logic [W-1:0]     r_thresh;
  logic [W-1:0]     r_cache_bound;
  logic             r_cache_valid;
  logic [W-1:0]     r_out_data;
  logic [REJ_W-1:0] r_rej;

  logic         w_req_fire;
  logic         w_rnd_fire;
  logic         w_out_fire;
  logic         w_cache_hit;
  logic         w_div_start;
  logic         w_div_busy;
  logic         w_div_done;
  logic [W-1:0] w_div_rem;
  logic [W-1:0] w_neg_bound;
  logic         w_accept;

  assign w_req_fire  = bus.req_valid && r_req_ready;
  assign w_rnd_fire  = bus.rnd_valid && r_rnd_ready;
  assign w_out_fire  = bus.out_ready && r_out_valid;
  assign w_cache_hit = r_cache_valid && (bus.req_bound == r_cache_bound);
  assign w_div_start = w_req_fire && (bus.req_bound != '0) && !w_cache_hit && !w_div_busy;
  // (2^W - s) mod 2^W is the two's complement of s.
  assign w_neg_bound = ~bus.req_bound + 1'b1;
  assign w_accept    = r_pass || (r_m[W-1:0] >= r_thresh);

  pcg_mod_serial #(.W(W)) u_mod (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_neg_bound),
    .i_divisor  (bus.req_bound),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_rem      (w_div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_fire) begin
          if ((bus.req_bound == '0) || w_cache_hit) begin
            w_state_next = ST_DRAW;
          end else begin
            w_state_next = ST_THRESH;
          end
        end
      end
      ST_THRESH: begin
        if (w_div_done) begin
          w_state_next = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (w_rnd_fire) begin
          w_state_next = ST_MUL;
        end
      end
      ST_MUL:   w_state_next = ST_CHECK;
      ST_CHECK: w_state_next = w_accept ? ST_OUT : ST_DRAW;
      ST_OUT: begin
        if (w_out_fire) begin
          w_state_next = ST_IDLE;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they read 0 throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_rnd_ready <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_req_ready <= (w_state_next == ST_IDLE);
      r_rnd_ready <= (w_state_next == ST_DRAW);
      r_out_valid <= (w_state_next == ST_OUT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s           <= '0;
      r_pass        <= 1'b0;
      r_x           <= '0;
      r_m           <= '0;
      r_thresh      <= '0;
      r_cache_bound <= '0;
      r_cache_valid <= 1'b0;
      r_out_data    <= '0;
      r_rej         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_s    <= bus.req_bound;
            r_pass <= (bus.req_bound == '0);
          end
        end
        ST_THRESH: begin
          if (w_div_done) begin
            r_thresh      <= w_div_rem;
            r_cache_bound <= r_s;
            r_cache_valid <= 1'b1;
          end
        end
        ST_DRAW: begin
          if (w_rnd_fire) begin
            r_x <= bus.rnd_data;
          end
        end
        ST_MUL: begin
          r_m <= {{W{1'b0}}, r_x} * {{W{1'b0}}, r_s};
        end
        ST_CHECK: begin
          if (w_accept) begin
            r_out_data <= r_pass ? r_x : r_m[2*W-1:W];
          end else if (r_rej != '1) begin
            r_rej <= r_rej + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rnd_ready = r_rnd_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.rej_count = r_rej;

endmodule
